// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: CPU (port 0) and loader (port 1).
// Optional build macro DMEM_ARB_CPU_PRIO_EN gives port 0 strict priority instead of round-robin.
module dmem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [DW-1:0]    wd0,
    output logic             ack0,
    output logic [DW-1:0]    rd0,
    output logic             cpu_stall,
    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [DW-1:0]    wd1,
    output logic             ack1,
    output logic [DW-1:0]    rd1,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wd,
    input  logic [DW-1:0]    mem_rd,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [DW-1:0]     wd_q,    wd_d;
    logic [CNT_W-1:0]  cnt0_q,  cnt1_q;
    logic              load;
    logic              win_idle;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign win_idle = ~req0;
`else
    // On a tie the port that was not served last wins.
    assign win_idle = (req0 && req1) ? ~last_q : ~req0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACC;
                    owner_d = win_idle;
                    load    = 1'b1;
                end
            end
            ACC: begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                if (req0) begin
                    owner_d = 1'b0;
                    load    = 1'b1;
                end else if (req1) begin
                    owner_d = 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                // The owner's own req is ignored; only the other port can take the next slot.
                if (owner_q ? req0 : req1) begin
                    owner_d = ~owner_q;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        last_d = load ? owner_d : last_q;
        we_d   = load ? (owner_d ? we1   : we0)   : we_q;
        addr_d = load ? (owner_d ? addr1 : addr0) : addr_q;
        wd_d   = load ? (owner_d ? wd1   : wd0)   : wd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == ACC) begin
            if (owner_q) cnt1_q <= cnt1_q + 1'b1;
            else         cnt0_q <= cnt0_q + 1'b1;
        end
    end

    always_comb begin
        ack0      = (state_q == ACC) && !owner_q;
        ack1      = (state_q == ACC) &&  owner_q;
        rd0       = ack0 ? mem_rd : '0;
        rd1       = ack1 ? mem_rd : '0;
        cpu_stall = req0 && !ack0;
        mem_we    = (state_q == ACC) && we_q;
        mem_addr  = (state_q == ACC) ? addr_q : '0;
        mem_wd    = (state_q == ACC) ? wd_q   : '0;
        gnt_cnt0  = cnt0_q;
        gnt_cnt1  = cnt1_q;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (dmem) between two requesters.
  - Port 0: the pipelined ARM core's memory stage.
  - Port 1: a loader/debug agent that preloads and inspects data memory.
- Sits between the core and dmem inside the top level; dmem itself is unchanged.
- Registered two-state FSM with round-robin arbitration, per-port request latching, a CPU stall output and per-port grant counters.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately; released synchronously to clk by the system.
- req0  input  1  CPU access request; held until ack0.
- we0  input  1  CPU write enable (1 = write, 0 = read).
- addr0  input  AW  CPU byte address.
- wd0  input  DW  CPU write data.
- ack0  output  1  CPU access served this cycle.
- rd0  output  DW  CPU read data; valid when ack0=1.
- cpu_stall  output  1  req0 & ~ack0; feeds the hazard unit.
- req1, we1, addr1, wd1, ack1, rd1: same as port 0, for the loader.
- mem_we  output  1  to dmem WE.
- mem_addr  output  AW  to dmem A.
- mem_wd  output  DW  to dmem WD.
- mem_rd  input  DW  from dmem RD; combinational read.
- gnt_cnt0  output  CNT_W  number of port-0 accesses served.
- gnt_cnt1  output  CNT_W  number of port-1 accesses served.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=0, last=1.
  - Latched we/addr/wd cleared to 0.
  - gnt_cnt0=gnt_cnt1=0.
  - Outputs ack0=ack1=0, mem_we=0, mem_addr=0, mem_wd=0, rd0=rd1=0, cpu_stall=req0.
- States: IDLE, ACC.
- IDLE:
  - No memory access; mem_we=0.
  - If any req is high, the arbiter picks a winner:
    - one requester → it wins;
    - both → the port != last wins (round-robin).
  - At the clock edge: owner=winner, last=winner, the winner's we/addr/wd are latched, state→ACC.
  - No req → stay in IDLE.
- ACC (exactly one cycle per access):
  - mem_we/mem_addr/mem_wd are driven from the latched request.
  - ack_owner=1 and rd_owner=mem_rd (combinational pass-through); the other ack=0.
  - A write commits at the closing edge of ACC.
  - gnt_cnt_owner increments at that edge; it wraps from 2^CNT_W-1 to 0.
- Next state from ACC:
  - If the non-owner's req=1: owner=other, last=other, its request is latched, and the FSM stays in ACC (back-to-back).
  - Else → IDLE.
  - The owner's own req is ignored during its ACC cycle.
- Latency: a req rising in IDLE is acked in the next cycle (1 cycle). Maximum wait for a requester when the other port is active is 2 cycles.
- Requester rule:
  - Hold req/we/addr/wd stable until the ack cycle.
  - Deassert req, or present a new request, from the cycle after ack.
  - A req still high after ack is a new access.
  - Changing addr/wd while waiting is undefined for the bench; the latched values are used.
- cpu_stall is combinational: 1 while req0 is high and not acked; 0 when idle.
- Simultaneous req0/req1 from reset: CPU is served first (last=1), then the loader in the following cycle.
- Reset asserted mid-ACC: the access is aborted, the pending write does not commit (mem_we forced 0 immediately), and no ack is issued.
- mem_rd is don't-care outside ACC; rd0/rd1 read 0 when their ack is 0.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined:
  - Port 0 always wins any tie, in IDLE and on the ACC→ACC handoff. From ACC with owner=1, a pending req0 still takes the next slot.
  - Port 1 is served only when req0=0, so the loader can starve; this is intended for run-time debug.
- Undefined: round-robin as described above.
- gnt counters and cpu_stall are unaffected by the macro.

Test Plan:
- Reset then single CPU read: req0=1, we0=0, addr0=0x10, mem returns 0xDEADBEEF → ack0 in cycle 2 with rd0=0xDEADBEEF; cpu_stall=1 in cycle 1, 0 in cycle 2; gnt_cnt0=1.
- Loader write then CPU read of the same address: req1 write 0x20←0x12345678, then req0 read 0x20 → rd0=0x12345678; mem_we high for exactly one cycle.
- Simultaneous req0/req1 from reset with both held continuously → acks alternate 0,1,0,1 with no IDLE gap; after 8 acks, gnt_cnt0=gnt_cnt1=4. With DMEM_ARB_CPU_PRIO_EN defined, ack1 never asserts while req0 is held.
- Reset dropped during an ACC write to 0x30 → mem_we falls immediately, the memory at 0x30 is unchanged, and the FSM is in IDLE with all outputs at reset values.
- Counter wrap with CNT_W=4: 17 CPU accesses → gnt_cnt0=1.
- No requests for 10 cycles → mem_we=0, ack0=ack1=0, and the FSM remains in IDLE.
